// File: rtl/led_spi_tx.sv
// led_spi_tx: backlight-LED serial transmitter.
// Pops one frame of zone brightness bytes from the zone-mean FIFO, frames them
// as header + zone bytes + checksum and shifts them out MSB-first on a mode-0
// SPI-style link (sclk idle low, data changes with sclk low, sampled on rise).
// Runs entirely in the FIFO read-clock domain.
module led_spi_tx #(
    parameter int         ZONES   = 40,
    parameter int         RD_LAT  = 2,
    parameter int         CLK_DIV = 4,
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter int         TIMEOUT = 1024
) (
    input  logic       rd_clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       rd_start,
    output logic       led_cs_n,
    output logic       led_sclk,
    output logic       led_sdo,
    output logic       busy,
    output logic       frame_done,
    output logic       underflow
);

    // Counter widths; each guarded so a parameter value of 1 still yields a
    // legal one-bit counter.
    localparam int DIV_W   = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam int ZONE_W  = (ZONES > 1) ? $clog2(ZONES + 1) : 1;
    localparam int LAT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    // Terminal counts. The divider runs 0..2*CLK_DIV-1 over one bit cell and
    // raises sclk once the first CLK_DIV cycles (data setup) have elapsed.
    localparam logic [DIV_W-1:0]   DIV_RISE   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(RD_LAT - 1);
    localparam logic [ZONE_W-1:0]  ZONE_LAST  = ZONE_W'(ZONES - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_REQ,
        S_WAIT,
        S_SHIFT,
        S_CSUM,
        S_END
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_divCnt;
    logic [2:0]          r_bitCnt;
    logic [6:0]          r_shift;
    logic [ZONE_W-1:0]   r_zoneCnt;
    logic [LAT_W-1:0]    r_latCnt;
    logic [STALL_W-1:0]  r_stallCnt;
    logic [7:0]          r_csum;

    logic                r_rdStart;
    logic                r_csN;
    logic                r_sclk;
    logic                r_sdo;
    logic                r_busy;
    logic                r_done;
    logic                r_uflow;

    logic                w_cellEnd;
    logic                w_sclkRise;
    logic                w_lastBit;
    logic                w_shifting;

    // Bit-cell timing decodes shared by the header, zone and checksum bytes.
    assign w_cellEnd  = (r_divCnt == DIV_LAST);
    assign w_sclkRise = (r_divCnt == DIV_RISE);
    assign w_lastBit  = (r_bitCnt == 3'd7);
    assign w_shifting = (r_state == S_HDR) || (r_state == S_SHIFT) || (r_state == S_CSUM);

    assign rd_start   = r_rdStart;
    assign led_cs_n   = r_csN;
    assign led_sclk   = r_sclk;
    assign led_sdo    = r_sdo;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign underflow  = r_uflow;

    // Frame sequencer: all outputs are registered here so that the link pins
    // and the one-cycle pulses never glitch. The shifter holds only the bits
    // still to be sent; led_sdo always carries the current bit directly.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_divCnt   <= '0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_zoneCnt  <= '0;
            r_latCnt   <= '0;
            r_stallCnt <= '0;
            r_csum     <= '0;
            r_rdStart  <= 1'b0;
            r_csN      <= 1'b1;
            r_sclk     <= 1'b0;
            r_sdo      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_uflow    <= 1'b0;
        end else begin
            r_rdStart <= 1'b0;
            r_done    <= 1'b0;
            r_uflow   <= 1'b0;

            if (w_shifting) begin
                if (w_cellEnd) begin
                    r_divCnt <= '0;
                    r_sclk   <= 1'b0;
                    if (!w_lastBit) begin
                        r_bitCnt <= r_bitCnt + 3'd1;
                        r_sdo    <= r_shift[6];
                        r_shift  <= {r_shift[5:0], 1'b0};
                    end
                end else begin
                    r_divCnt <= r_divCnt + 1'b1;
                    if (w_sclkRise) begin
                        r_sclk <= 1'b1;
                    end
                end
            end

            case (r_state)
                S_IDLE: begin
                    r_stallCnt <= '0;
                    if (frame_start && !fifo_empty) begin
                        r_state   <= S_HDR;
                        r_busy    <= 1'b1;
                        r_csN     <= 1'b0;
                        r_sclk    <= 1'b0;
                        r_sdo     <= HEADER[7];
                        r_shift   <= HEADER[6:0];
                        r_divCnt  <= '0;
                        r_bitCnt  <= '0;
                        r_zoneCnt <= '0;
                        r_csum    <= '0;
                    end
                end

                S_HDR: begin
                    if (w_cellEnd && w_lastBit) begin
                        r_state <= S_REQ;
                        r_sdo   <= 1'b0;
                    end
                end

                S_REQ: begin
                    if (!fifo_empty) begin
                        r_rdStart  <= 1'b1;
                        r_stallCnt <= '0;
                        r_latCnt   <= '0;
                        r_state    <= S_WAIT;
                    end else if (r_stallCnt == STALL_LAST) begin
                        r_stallCnt <= '0;
                        r_csN      <= 1'b1;
                        r_uflow    <= 1'b1;
                        r_state    <= S_END;
                    end else begin
                        r_stallCnt <= r_stallCnt + 1'b1;
                    end
                end

                S_WAIT: begin
                    if (r_latCnt == LAT_LAST) begin
                        r_sdo    <= fifo_dout[7];
                        r_shift  <= fifo_dout[6:0];
                        r_csum   <= r_csum + fifo_dout;
                        r_divCnt <= '0;
                        r_bitCnt <= '0;
                        r_state  <= S_SHIFT;
                    end else begin
                        r_latCnt <= r_latCnt + 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (w_cellEnd && w_lastBit) begin
                        r_zoneCnt <= r_zoneCnt + 1'b1;
                        if (r_zoneCnt == ZONE_LAST) begin
                            r_sdo    <= r_csum[7];
                            r_shift  <= r_csum[6:0];
                            r_bitCnt <= '0;
                            r_state  <= S_CSUM;
                        end else begin
                            r_sdo   <= 1'b0;
                            r_state <= S_REQ;
                        end
                    end
                end

                S_CSUM: begin
                    if (w_cellEnd && w_lastBit) begin
                        r_csN   <= 1'b1;
                        r_sdo   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_END;
                    end
                end

                S_END: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_spi_tx.sv
// tb_led_spi_tx: directed + randomized bench for led_spi_tx.
// A queue-based FIFO model feeds the DUT; a bit-level receiver decodes the
// serial link. Expected frames are built from the bytes the bench pushed:
// header, the next ZONES bytes in FIFO order, then their sum mod 256.
module tb_led_spi_tx;

    localparam int         ZONES   = 40;
    localparam int         RD_LAT  = 2;
    localparam int         CLK_DIV = 4;
    localparam logic [7:0] HEADER  = 8'hA5;
    localparam int         TIMEOUT = 1024;

    // Cycles from the cycle after frame_start to the frame_done cycle.
    localparam int FRAME_EDGES = (ZONES + 2) * 8 * 2 * CLK_DIV + ZONES * (1 + RD_LAT);
    // Cycles from the last rd_start to underflow: read latency tail, one byte
    // shift, TIMEOUT stalled request cycles, then the abort cycle.
    localparam int UFLOW_LAT = (RD_LAT - 1) + 8 * 2 * CLK_DIV + TIMEOUT + 1;

    logic       rd_clk;
    logic       rst_n;
    logic       frame_start;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       rd_start;
    logic       led_cs_n;
    logic       led_sclk;
    logic       led_sdo;
    logic       busy;
    logic       frame_done;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifoQ[$];
    logic [7:0] pushQ[$];
    logic [7:0] expQ[$];
    logic [7:0] rxQ[$];
    logic [7:0] rxByte = 8'h00;
    int         rxBits = 0;

    int cycleCnt     = 0;
    int popCnt       = 0;
    int doneCnt      = 0;
    int uflowCnt     = 0;
    int lastPopCycle = 0;
    int uflowCycle   = 0;
    int popEmptyErr  = 0;
    int idleSclkErr  = 0;
    int sclkRunErr   = 0;
    int highRun      = 0;

    led_spi_tx #(
        .ZONES   (ZONES),
        .RD_LAT  (RD_LAT),
        .CLK_DIV (CLK_DIV),
        .HEADER  (HEADER),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .rd_clk      (rd_clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .rd_start    (rd_start),
        .led_cs_n    (led_cs_n),
        .led_sclk    (led_sclk),
        .led_sdo     (led_sdo),
        .busy        (busy),
        .frame_done  (frame_done),
        .underflow   (underflow)
    );

    // Free-running read clock.
    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    // FIFO model: a sampled rd_start counts as the first latency cycle, so the
    // popped byte is on dout for exactly the following cycle and is replaced
    // by junk afterwards. Bytes queued by the stimulus land on the next edge.
    always @(posedge rd_clk) begin
        if (rd_start) begin
            if (fifoQ.size() == 0) begin
                popEmptyErr++;
                fifo_dout <= 8'($urandom);
            end else begin
                fifo_dout <= fifoQ.pop_front();
            end
        end else begin
            fifo_dout <= 8'($urandom);
        end
        while (pushQ.size() > 0) begin
            fifoQ.push_back(pushQ.pop_front());
        end
        fifo_empty <= (fifoQ.size() == 0);
    end

    // Cycle monitor: counts pulses and watches sclk idle level and high time.
    always @(negedge rd_clk) begin
        cycleCnt++;
        if (rd_start) begin
            popCnt++;
            lastPopCycle = cycleCnt;
        end
        if (frame_done) begin
            doneCnt++;
        end
        if (underflow) begin
            uflowCnt++;
            uflowCycle = cycleCnt;
        end
        if (led_cs_n && led_sclk) begin
            idleSclkErr++;
        end
        if (!rst_n) begin
            highRun = 0;
        end else if (led_sclk) begin
            highRun++;
        end else begin
            if (highRun != 0 && highRun != CLK_DIV) begin
                sclkRunErr++;
            end
            highRun = 0;
        end
    end

    // Link receiver: samples led_sdo on each sclk rising edge while selected.
    always @(posedge led_sclk) begin
        if (!led_cs_n) begin
            rxByte = {rxByte[6:0], led_sdo};
            rxBits++;
            if (rxBits == 8) begin
                rxQ.push_back(rxByte);
                rxBits = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        @(negedge rd_clk);
        frame_start = 1'b1;
        @(negedge rd_clk);
        frame_start = 1'b0;
    endtask

    task automatic pushByte(input logic [7:0] b);
        pushQ.push_back(b);
        expQ.push_back(b);
    endtask

    task automatic clearRx();
        rxQ.delete();
        rxBits = 0;
    endtask

    task automatic dropExpected(input int n);
        for (int i = 0; i < n; i++) begin
            if (expQ.size() > 0) begin
                void'(expQ.pop_front());
            end
        end
    endtask

    function automatic logic [7:0] rxAt(input int idx);
        return (idx < rxQ.size()) ? rxQ[idx] : 8'h00;
    endfunction

    task automatic waitFrameEnd(input string tag, input int limit, output int n);
        n = 0;
        while (frame_done !== 1'b1 && underflow !== 1'b1 && n < limit) begin
            @(negedge rd_clk);
            n++;
        end
        checkOutput({tag, "_end_seen"}, 32'(frame_done | underflow), 32'd1);
    endtask

    task automatic expectFrame(input string tag);
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'h00;
        checkOutput({tag, "_len"}, 32'(rxQ.size()), 32'(ZONES + 2));
        checkOutput({tag, "_hdr"}, 32'(rxAt(0)), 32'(HEADER));
        for (int i = 0; i < ZONES; i++) begin
            b = (expQ.size() > 0) ? expQ.pop_front() : 8'h00;
            sum = sum + b;
            checkOutput($sformatf("%s_zone%0d", tag, i), 32'(rxAt(i + 1)), 32'(b));
        end
        checkOutput({tag, "_csum"}, 32'(rxAt(ZONES + 1)), 32'(sum));
    endtask

    // Directed sequence with randomized frame contents.
    initial begin
        int n;
        int k;
        int p0;
        int d0;
        int u0;
        int seenCsLow;
        int seenBusy;
        int seenSclk;

        rst_n       = 1'b0;
        frame_start = 1'b0;
        $display("[TB] start");

        repeat (3) @(negedge rd_clk);
        checkOutput("rst_cs_n", 32'(led_cs_n), 32'd1);
        checkOutput("rst_sclk", 32'(led_sclk), 32'd0);
        checkOutput("rst_sdo", 32'(led_sdo), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rd_start", 32'(rd_start), 32'd0);
        checkOutput("rst_done", 32'(frame_done), 32'd0);
        checkOutput("rst_uflow", 32'(underflow), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge rd_clk);

        // frame_start against an empty FIFO is dropped silently.
        p0 = popCnt;
        seenCsLow = 0;
        seenBusy = 0;
        applyStimulus();
        for (int i = 0; i < 20; i++) begin
            if (!led_cs_n) seenCsLow++;
            if (busy) seenBusy++;
            @(negedge rd_clk);
        end
        checkOutput("empty_cs_low", 32'(seenCsLow), 32'd0);
        checkOutput("empty_busy", 32'(seenBusy), 32'd0);
        checkOutput("empty_pops", 32'(popCnt - p0), 32'd0);

        // Counting pattern 0..39 with timing checks.
        clearRx();
        for (int i = 0; i < ZONES; i++) pushByte(8'(i));
        p0 = popCnt;
        d0 = doneCnt;
        u0 = uflowCnt;
        applyStimulus();
        checkOutput("cnt_busy_t1", 32'(busy), 32'd1);
        checkOutput("cnt_cs_t1", 32'(led_cs_n), 32'd0);
        checkOutput("cnt_sdo_t1", 32'(led_sdo), 32'(HEADER[7]));
        checkOutput("cnt_sclk_t1", 32'(led_sclk), 32'd0);
        waitFrameEnd("cnt", 4000, n);
        checkOutput("cnt_length", 32'(n), 32'(FRAME_EDGES));
        checkOutput("cnt_cs_at_done", 32'(led_cs_n), 32'd1);
        @(negedge rd_clk);
        checkOutput("cnt_busy_after", 32'(busy), 32'd0);
        checkOutput("cnt_done_pulse", 32'(frame_done), 32'd0);
        checkOutput("cnt_csum_lit", 32'(rxAt(ZONES + 1)), 32'h0C);
        expectFrame("cnt");
        checkOutput("cnt_pops", 32'(popCnt - p0), 32'(ZONES));
        checkOutput("cnt_dones", 32'(doneCnt - d0), 32'd1);
        checkOutput("cnt_uflows", 32'(uflowCnt - u0), 32'd0);

        // Random frames.
        for (int f = 0; f < 2; f++) begin
            clearRx();
            for (int i = 0; i < ZONES; i++) pushByte(8'($urandom_range(0, 255)));
            p0 = popCnt;
            applyStimulus();
            waitFrameEnd("rnd", 4000, n);
            @(negedge rd_clk);
            expectFrame($sformatf("rnd%0d", f));
            checkOutput("rnd_pops", 32'(popCnt - p0), 32'(ZONES));
        end

        // 20 bytes now, 20 more after a stall; sclk must rest low meanwhile.
        clearRx();
        for (int i = 0; i < 20; i++) pushByte(8'hFF);
        p0 = popCnt;
        d0 = doneCnt;
        u0 = uflowCnt;
        applyStimulus();
        k = 0;
        while (popCnt - p0 < 20 && k < 3000) begin
            @(negedge rd_clk);
            k++;
        end
        seenSclk = 0;
        seenCsLow = 0;
        for (int i = 1; i <= 150; i++) begin
            @(negedge rd_clk);
            if (i >= 70 && led_sclk) seenSclk++;
            if (i >= 70 && !led_cs_n) seenCsLow++;
        end
        checkOutput("stall_sclk_high", 32'(seenSclk), 32'd0);
        checkOutput("stall_cs_low_cycles", 32'(seenCsLow), 32'd81);
        checkOutput("stall_pops", 32'(popCnt - p0), 32'd20);
        for (int i = 0; i < 20; i++) pushByte(8'hFF);
        waitFrameEnd("stall", 4000, n);
        @(negedge rd_clk);
        checkOutput("stall_csum_lit", 32'(rxAt(ZONES + 1)), 32'hD8);
        expectFrame("stall");
        checkOutput("stall_dones", 32'(doneCnt - d0), 32'd1);
        checkOutput("stall_uflows", 32'(uflowCnt - u0), 32'd0);

        // Only 10 bytes ever supplied: timeout abort.
        clearRx();
        for (int i = 0; i < 10; i++) pushByte(8'($urandom_range(0, 255)));
        p0 = popCnt;
        d0 = doneCnt;
        u0 = uflowCnt;
        applyStimulus();
        waitFrameEnd("uf", 4000, n);
        checkOutput("uf_pulse", 32'(underflow), 32'd1);
        checkOutput("uf_cs", 32'(led_cs_n), 32'd1);
        checkOutput("uf_no_done", 32'(frame_done), 32'd0);
        @(negedge rd_clk);
        checkOutput("uf_busy_after", 32'(busy), 32'd0);
        checkOutput("uf_pulse_len", 32'(underflow), 32'd0);
        checkOutput("uf_pops", 32'(popCnt - p0), 32'd10);
        checkOutput("uf_count", 32'(uflowCnt - u0), 32'd1);
        checkOutput("uf_dones", 32'(doneCnt - d0), 32'd0);
        checkOutput("uf_latency", 32'(uflowCycle - lastPopCycle), 32'(UFLOW_LAT));
        checkOutput("uf_rx_bytes", 32'(rxQ.size()), 32'd11);
        dropExpected(10);

        // Second frame_start mid-frame is ignored, not queued.
        clearRx();
        for (int i = 0; i < ZONES + 1; i++) pushByte(8'($urandom_range(0, 255)));
        p0 = popCnt;
        d0 = doneCnt;
        applyStimulus();
        repeat (500) @(negedge rd_clk);
        applyStimulus();
        waitFrameEnd("mid", 4000, n);
        @(negedge rd_clk);
        expectFrame("mid");
        seenBusy = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy) seenBusy++;
            @(negedge rd_clk);
        end
        checkOutput("mid_no_restart", 32'(seenBusy), 32'd0);
        checkOutput("mid_pops", 32'(popCnt - p0), 32'(ZONES));
        checkOutput("mid_dones", 32'(doneCnt - d0), 32'd1);

        // Asynchronous reset while zone byte 5 is shifting.
        clearRx();
        for (int i = 0; i < 45; i++) pushByte(8'($urandom_range(0, 255)));
        p0 = popCnt;
        applyStimulus();
        k = 0;
        while (popCnt - p0 < 6 && k < 3000) begin
            @(negedge rd_clk);
            k++;
        end
        repeat (20) @(negedge rd_clk);
        d0 = doneCnt;
        u0 = uflowCnt;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_cs_n", 32'(led_cs_n), 32'd1);
        checkOutput("arst_sclk", 32'(led_sclk), 32'd0);
        checkOutput("arst_sdo", 32'(led_sdo), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_rd_start", 32'(rd_start), 32'd0);
        repeat (3) @(negedge rd_clk);
        rst_n = 1'b1;
        @(negedge rd_clk);
        checkOutput("arst_pops", 32'(popCnt - p0), 32'd6);
        checkOutput("arst_no_done", 32'(doneCnt - d0), 32'd0);
        checkOutput("arst_no_uflow", 32'(uflowCnt - u0), 32'd0);
        dropExpected(6);
        clearRx();
        p0 = popCnt;
        applyStimulus();
        waitFrameEnd("post", 4000, n);
        @(negedge rd_clk);
        expectFrame("post");
        checkOutput("post_pops", 32'(popCnt - p0), 32'(ZONES));

        checkOutput("pop_when_empty", 32'(popEmptyErr), 32'd0);
        checkOutput("sclk_while_deselected", 32'(idleSclkErr), 32'd0);
        checkOutput("sclk_high_time", 32'(sclkRunErr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
